// File: rtl/sweep_pkg.sv
// Shared types and helpers for the stimulus sweep generator:
// FSM state encoding, dwell counter width and binary/Gray pattern encoding.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    // Dwell counter width; covers DWELL up to 65535.
    localparam int unsigned DWELL_CNT_W = 16;

    // Map a sweep index onto the pattern driven to the DUT.
    function automatic logic [31:0] sweep_encode(input logic [31:0] idx, input logic gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

endpackage

// File: rtl/sweep_sig_acc.sv
// Response signature accumulator: rotate-left-by-one then XOR in the
// zero-extended response on each enabled cycle; synchronous clear.
module sweep_sig_acc #(
    parameter int unsigned SIG_W = 16,
    parameter int unsigned OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [OUT_W-1:0] resp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Next signature: clear wins over accumulate.
    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = ((sig_q << 1) | (sig_q >> (SIG_W - 1))) ^ SIG_W'(resp);
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/stim_sweep_gen.sv
// Exhaustive stimulus sweep generator: drives all 2^IN_W patterns in binary
// or Gray order, holds each for DWELL cycles, then strobes one sample cycle.
// Optional response signature enabled by defining STIM_SWEEP_SIG_EN.
module stim_sweep_gen
    import sweep_pkg::*;
#(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 2,
    parameter int unsigned DWELL = 4,
    parameter int unsigned SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_gray,
    input  logic [OUT_W-1:0] resp,
    output logic [IN_W-1:0]  stim,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig
);

    localparam logic [IN_W-1:0]        IDX_LAST = '1;
    localparam logic [DWELL_CNT_W-1:0] CNT_LOAD = DWELL_CNT_W'(DWELL - 1);

    sweep_state_e           state_q, state_d;
    logic [IN_W-1:0]        idx_q, idx_d;
    logic [IN_W-1:0]        idx_nxt;
    logic [DWELL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   gray_q, gray_d;
    logic [IN_W-1:0]        stim_q, stim_d;
    logic                   go;

    assign go      = (state_q == ST_IDLE) && start && !abort;
    assign idx_nxt = idx_q + 1'b1;

    // Next-state logic; stim is computed alongside the index so it is registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gray_d  = gray_q;
        stim_d  = stim_q;
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            stim_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_DRIVE;
                        idx_d   = '0;
                        cnt_d   = CNT_LOAD;
                        gray_d  = mode_gray;
                        stim_d  = '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        stim_d  = '0;
                    end else begin
                        state_d = ST_DRIVE;
                        idx_d   = idx_nxt;
                        cnt_d   = CNT_LOAD;
                        stim_d  = IN_W'(sweep_encode(32'(idx_nxt), gray_q));
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    stim_d  = '0;
                end
            endcase
        end
    end

    // Sweep state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gray_q  <= 1'b0;
            stim_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            stim_q  <= stim_d;
        end
    end

    assign stim   = stim_q;
    assign sample = (state_q == ST_SAMPLE);
    assign busy   = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done   = (state_q == ST_DONE);

`ifdef STIM_SWEEP_SIG_EN
    // An abort coinciding with the sample cycle leaves the partial signature untouched.
    logic sig_clear;
    logic sig_en;

    assign sig_clear = go;
    assign sig_en    = sample && !abort;

    sweep_sig_acc #(
        .SIG_W(SIG_W),
        .OUT_W(OUT_W)
    ) u_sig_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sig_clear),
        .enable(sig_en),
        .resp  (resp),
        .sig   (sig)
    );
`else
    logic unused_resp;
    logic unused_go;

    assign unused_resp = ^resp;
    assign unused_go   = go;
    assign sig         = '0;
`endif

endmodule
